// File: rtl/dbus_handshake_if.sv
// Signal bundle between the memory stage, the dbus adapter and the data bus.
// The misalign flag exists only when DBUS_ALIGN_CHECK_EN is defined.
interface dbus_handshake_if;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        stall;
    logic        rdata_valid;
    logic [63:0] rdata;
    logic        bus_err;
`ifdef DBUS_ALIGN_CHECK_EN
    logic        misalign;
`endif
    logic        bus_valid;
    logic [63:0] bus_addr;
    logic [1:0]  bus_size;
    logic [7:0]  bus_strobe;
    logic [63:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [63:0] bus_rdata;

    // master: the adapter itself; slave: core + bus environment around it
    modport master (
`ifdef DBUS_ALIGN_CHECK_EN
        output misalign,
`endif
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stall, rdata_valid, rdata, bus_err,
        output bus_valid, bus_addr, bus_size, bus_strobe, bus_wdata
    );

    modport slave (
`ifdef DBUS_ALIGN_CHECK_EN
        input  misalign,
`endif
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stall, rdata_valid, rdata, bus_err,
        input  bus_valid, bus_addr, bus_size, bus_strobe, bus_wdata
    );
endinterface

// File: rtl/dbus_handshake.sv
// Memory-stage to dbus adapter: holds one load/store as a valid/addr_ok/data_ok transaction.
// Define DBUS_ALIGN_CHECK_EN to complete misaligned requests locally with a misalign pulse.
module dbus_handshake #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic             clk,
    input logic             reset,
    dbus_handshake_if.master dbus
);
    localparam int unsigned CntW = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {StIdle, StReq, StWaitData, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [63:0]       addr_q, wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [7:0]        strobe_q;
    logic [7:0]        strobe_base;
    logic [63:0]       shifted;
    logic [63:0]       load_ext;
    logic              accept;
    logic              wd_fire;
    logic              misaligned;

    assign accept  = (state_q == StIdle) && dbus.req_valid;
    assign wd_fire = (MAX_WAIT != 0) && (cnt_q == CntW'(MAX_WAIT - 1));

    always_comb begin
        strobe_base = 8'h00;
        misaligned  = 1'b0;
        case (dbus.req_size)
            2'd0: begin strobe_base = 8'h01; misaligned = 1'b0;                end
            2'd1: begin strobe_base = 8'h03; misaligned = dbus.req_addr[0];    end
            2'd2: begin strobe_base = 8'h0F; misaligned = |dbus.req_addr[1:0]; end
            default: begin strobe_base = 8'hFF; misaligned = |dbus.req_addr[2:0]; end
        endcase
    end

    // Bus word is 64-bit aligned; bring the addressed bytes down to bit 0 before extending.
    always_comb begin
        shifted  = dbus.bus_rdata >> {addr_q[2:0], 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = {{56{shifted[7]  & ~uns_q}}, shifted[7:0]};
            2'd1: load_ext = {{48{shifted[15] & ~uns_q}}, shifted[15:0]};
            2'd2: load_ext = {{32{shifted[31] & ~uns_q}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (dbus.req_valid) begin
                    state_d = StReq;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = StDone;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                // Completing data wins over a watchdog expiring in the same cycle.
                if (dbus.bus_addr_ok && dbus.bus_data_ok) begin
                    state_d = StDone;
                    rdata_d = load_ext;
                end else if (wd_fire) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (dbus.bus_addr_ok) begin
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                cnt_d = cnt_q + 1'b1;
                if (dbus.bus_data_ok) begin
                    state_d = StDone;
                    rdata_d = load_ext;
                end else if (wd_fire) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            mis_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q   <= dbus.req_addr;
                size_q   <= dbus.req_size;
                uns_q    <= dbus.req_unsigned;
                strobe_q <= dbus.req_write ? (strobe_base << dbus.req_addr[2:0]) : 8'h00;
                wdata_q  <= dbus.req_wdata << {dbus.req_addr[2:0], 3'b000};
            end
        end
    end

    assign dbus.stall       = accept || (state_q == StReq) || (state_q == StWaitData);
    assign dbus.rdata_valid = (state_q == StDone);
    assign dbus.bus_err     = (state_q == StDone) && err_q;
    assign dbus.rdata       = rdata_q;
    assign dbus.bus_valid   = (state_q == StReq);
    assign dbus.bus_addr    = addr_q;
    assign dbus.bus_size    = size_q;
    assign dbus.bus_strobe  = strobe_q;
    assign dbus.bus_wdata   = wdata_q;
`ifdef DBUS_ALIGN_CHECK_EN
    assign dbus.misalign    = (state_q == StDone) && mis_q;
`endif
endmodule

// File: tb/tb_dbus_handshake.sv
// Bench for dbus_handshake: transaction-level model predicts every cycle's outputs.
module tb_dbus_handshake;
    localparam int MaxWait = 4;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    dbus_handshake_if dbus ();

    dbus_handshake #(.MAX_WAIT(MaxWait)) u_dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Per-cycle expectations, set by the driver before each clock edge.
    bit          e_chk, e_stall, e_bvalid, e_rvalid, e_err, e_mis;
    bit          e_chk_bus, e_chk_rdata, e_chk_zero;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_size;
    logic [7:0]  e_strobe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_chk) begin
            chk("stall", 64'(dbus.stall), 64'(e_stall));
            chk("bus_valid", 64'(dbus.bus_valid), 64'(e_bvalid));
            chk("rdata_valid", 64'(dbus.rdata_valid), 64'(e_rvalid));
            chk("bus_err", 64'(dbus.bus_err), 64'(e_err));
`ifdef DBUS_ALIGN_CHECK_EN
            chk("misalign", 64'(dbus.misalign), 64'(e_mis));
`endif
            if (e_chk_bus) begin
                chk("bus_addr", dbus.bus_addr, e_addr);
                chk("bus_size", 64'(dbus.bus_size), 64'(e_size));
                chk("bus_strobe", 64'(dbus.bus_strobe), 64'(e_strobe));
                chk("bus_wdata", dbus.bus_wdata, e_wdata);
            end
            if (e_chk_rdata) chk("rdata", dbus.rdata, e_rdata);
            if (e_chk_zero) begin
                chk("rst_rdata", dbus.rdata, 64'd0);
                chk("rst_bus_addr", dbus.bus_addr, 64'd0);
                chk("rst_bus_size", 64'(dbus.bus_size), 64'd0);
                chk("rst_bus_strobe", 64'(dbus.bus_strobe), 64'd0);
                chk("rst_bus_wdata", dbus.bus_wdata, 64'd0);
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: plain byte arithmetic on the request fields.
    function automatic logic [63:0] m_load(logic [63:0] rd, int off, int size, bit uns);
        int nb = 1 << size;
        logic [63:0] v, mask;
        v = rd >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] m_strobe(bit w, int off, int size);
        int unsigned m;
        if (!w) return 8'h00;
        m = ((32'd1 << (1 << size)) - 32'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(logic [63:0] wd, int off);
        return wd << (8 * off);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit st, input bit bv, input bit rv, input bit er);
        e_chk = 1'b1; e_stall = st; e_bvalid = bv; e_rvalid = rv; e_err = er; e_mis = 1'b0;
        e_chk_bus = 1'b0; e_chk_rdata = 1'b0; e_chk_zero = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            dbus.req_valid = 1'b0;
            dbus.req_addr = r64();
            dbus.bus_addr_ok = rb();
            dbus.bus_data_ok = rb();
            dbus.bus_rdata = r64();
            set_exp(0, 0, 0, 0);
            step();
        end
    endtask

    // a: REQ cycles before addr_ok; k: cycles from addr_ok to data_ok.
    task automatic run_txn(input bit w, input logic [63:0] addr, input logic [1:0] size,
                           input bit uns, input logic [63:0] wdata, input int a, input int k,
                           input logic [63:0] rd, input logic [63:0] exp_rd,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wd,
                           input bit done_rv);
        bit mis, abort;
        int lat;
        mis = 1'b0;
`ifdef DBUS_ALIGN_CHECK_EN
        mis = (addr % (64'd1 << size)) != 64'd0;
`endif
        abort = !mis && (MaxWait != 0) && (a + k + 1 > MaxWait);
        lat = mis ? 0 : (abort ? MaxWait : a + k + 1);
        dbus.req_valid = 1'b1; dbus.req_write = w; dbus.req_addr = addr;
        dbus.req_size = size; dbus.req_unsigned = uns; dbus.req_wdata = wdata;
        dbus.bus_addr_ok = rb(); dbus.bus_data_ok = rb(); dbus.bus_rdata = r64();
        set_exp(1, 0, 0, 0);
        step();
        for (int i = 1; i <= lat; i++) begin
            dbus.bus_addr_ok = (i == a + 1) || (i > a + 1 && rb());
            dbus.bus_data_ok = (i == a + 1 + k) || (i < a + 1 && rb());
            dbus.bus_rdata = (i == a + 1 + k) ? rd : r64();
            set_exp(1, i <= a + 1, 0, 0);
            if (i <= a + 1) begin
                e_chk_bus = 1'b1; e_addr = addr; e_size = size;
                e_strobe = exp_strb; e_wdata = exp_wd;
            end
            step();
        end
        dbus.req_valid = done_rv;
        dbus.bus_addr_ok = rb(); dbus.bus_data_ok = rb(); dbus.bus_rdata = r64();
        set_exp(0, 0, 1, abort);
        e_mis = mis;
        if (mis || abort || !w) begin
            e_chk_rdata = 1'b1;
            e_rdata = (mis || abort) ? 64'd0 : exp_rd;
        end
        step();
    endtask

    initial begin
        logic [63:0] addr, wd, rd;
        logic [1:0]  size;
        bit          w, uns;
        int          a, k;

        e_chk = 1'b0;
        reset = 1'b1;
        dbus.req_valid = 1'b0; dbus.req_write = 1'b0; dbus.req_addr = '0;
        dbus.req_size = '0; dbus.req_unsigned = 1'b0; dbus.req_wdata = '0;
        dbus.bus_addr_ok = 1'b0; dbus.bus_data_ok = 1'b0; dbus.bus_rdata = '0;
        step();
        step();
        reset = 1'b0;
        set_exp(0, 0, 0, 0);
        e_chk_zero = 1'b1;
        step();

        // LW signed from upper word: all-ones result, stall for exactly 2 cycles.
        run_txn(0, 64'h8000_0004, 2'd2, 0, 64'd0, 0, 0, 64'hFFFF_FFFF_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 0);
        idle(1);
        // SB to byte 3.
        run_txn(1, 64'h8000_0003, 2'd0, 0, 64'h0000_0000_0000_00AB, 0, 0, 64'd0,
                64'd0, 8'h08, 64'h0000_0000_AB00_0000, 0);
        idle(1);
        // addr_ok in first REQ cycle, data_ok 3 cycles later (WAIT_DATA path).
        run_txn(0, 64'h1000_0000, 2'd3, 1, 64'd0, 0, 3, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 8'h00, 64'd0, 0);
        idle(1);
        // Silent bus: watchdog aborts, DONE lands 5 cycles after accept.
        run_txn(0, 64'h2000_0000, 2'd2, 0, 64'd0, 20, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 8'h00, 64'd0, 0);
        idle(1);

        // Reset while waiting for data; the late data_ok must be ignored.
        dbus.req_valid = 1'b1; dbus.req_write = 1'b0; dbus.req_addr = 64'h40;
        dbus.req_size = 2'd3; dbus.bus_addr_ok = 1'b0; dbus.bus_data_ok = 1'b0;
        set_exp(1, 0, 0, 0); step();
        dbus.bus_addr_ok = 1'b1;
        set_exp(1, 1, 0, 0); step();
        dbus.bus_addr_ok = 1'b0;
        set_exp(1, 0, 0, 0); step();
        reset = 1'b1; dbus.req_valid = 1'b0; e_chk = 1'b0; step();
        reset = 1'b0; dbus.bus_data_ok = 1'b1;
        set_exp(0, 0, 0, 0); e_chk_zero = 1'b1; step();
        dbus.bus_data_ok = 1'b0;
        set_exp(0, 0, 0, 0); step();
        run_txn(0, 64'h48, 2'd1, 1, 64'd0, 1, 1, 64'h0000_0000_0000_8001,
                64'h0000_0000_0000_8001, 8'h00, 64'd0, 0);

        repeat (300) begin
            w = rb(); uns = rb(); size = 2'($urandom_range(0, 3));
            addr = r64(); wd = r64(); rd = r64();
            a = ($urandom_range(0, 9) > 7) ? 8 : int'($urandom_range(0, 3));
            k = int'($urandom_range(0, 3));
            run_txn(w, addr, size, uns, wd, a, k, rd,
                    m_load(rd, int'(addr[2:0]), int'(size), uns),
                    m_strobe(w, int'(addr[2:0]), int'(size)),
                    m_wdata(wd, int'(addr[2:0])), rb());
            if (rb()) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
